modcounter_gen: RTL and testbench
=================================

// Module: modcounter_gen
// PURPOSE
//  Parametrised multi-mode modulo counter; next generation of the 4-bit mod-N counter.
//  Adds generic width/modulus, programmable step, saturating modes and a bounce direction FSM.
//  Adds terminal-count/wrap pulses and an optional thermometer view.
//  Feeds timing/sequencing logic and LED/debug displays in the FPGA assignment designs.
// PARAMETERS
//  WIDTH   8    count width; MODULUS <= 2**WIDTH
//  MODULUS 200  count range 0..MODULUS-1; must be >= 2
//  STEP_W  4    width of step input
// PORTS
//  clk       in   1        single clock, all state on posedge
//  rst       in   1        synchronous, active-high reset
//  en        in   1        count enable; 0 = freeze all state
//  mode      in   3        0 up-wrap, 1 down-wrap, 2 bounce, 3 load, 4 hold, 5 up-sat, 6 down-sat, 7 hold
//  step      in   STEP_W   increment per enabled cycle
//  load_val  in   WIDTH    value for mode 3
//  count     out  WIDTH    current count, registered
//  dir       out  1        bounce direction, registered; 0 = up, 1 = down
//  wrap      out  1        1-cycle registered pulse, set with the update that wrapped or reversed
//  tc        out  1        combinational: count==MODULUS-1 (up modes) or count==0 (down modes)
//  load_err  out  1        1-cycle registered pulse when load_val >= MODULUS
//  thermo    out  MODULUS  thermometer code; present only with MODCNT_THERMO_EN
// BEHAVIOUR
//  Reset (rst=1 at posedge): count=0, dir=0, wrap=0, load_err=0. rst has priority over en.
//  Latency: count/dir/wrap/load_err update on the posedge after inputs are sampled.
//  Effective step: s = min(step, MODULUS-1). s==0 in modes 0/1/2/5/6: count holds and wrap=0.
//  Arithmetic uses a WIDTH+2-bit intermediate; no intermediate overflow is permitted.
//  en=0: count and dir hold; wrap=0 and load_err=0 the next cycle.
//  Mode 0: if count+s >= MODULUS, then count=count+s-MODULUS and wrap=1; else count+=s.
//  Mode 1: if count < s, then count=count+MODULUS-s and wrap=1; else count-=s.
//  Mode 2: bounce FSM with states UP(dir=0) and DOWN(dir=1).
//    UP: if count+s >= MODULUS-1, then count=MODULUS-1, ->DOWN, wrap=1; else count+=s.
//    DOWN: if count <= s, then count=0, ->UP, wrap=1; else count-=s.
//  Mode 3: count=load_val if load_val < MODULUS; else count=MODULUS-1 and load_err=1.
//  Modes 4/7: count holds; wrap=0.
//  Mode 5: count=min(count+s, MODULUS-1); no wrap.
//  Mode 6: count=max(count-s, 0); no wrap.
//  Any enabled mode other than 2 forces dir=0 (FSM to UP).
//    Re-entering mode 2 therefore always starts upward.
//  tc mode mapping: modes 0/2(UP)/5 -> count==MODULUS-1; 1/2(DOWN)/6 -> count==0; else 0.
//  Mode change mid-count: takes effect on the next edge, with no extra latency.
//  Reset mid-operation aborts everything, including pending pulses.
//  Count out of range (cannot occur post-reset) is treated as MODULUS-1.
// CONFIGURATION
//  MODCNT_THERMO_EN defined: thermo[i] = (i < count); count=0 gives all zeros.
//    thermo is combinational from count.
//  MODCNT_THERMO_EN undefined: thermo port and its logic are absent.
// STRUCTURE
//  Package modcounter_pkg: mode localparams
//    MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_LOAD, MODE_HOLD, MODE_UPSAT, MODE_DNSAT.
//  Package modcounter_pkg also holds bounce state constants ST_UP, ST_DOWN.
//  Sub-module modcounter_thermo #(WIDTH, MODULUS): count -> thermo.
//    Instantiated only under MODCNT_THERMO_EN.
//  Top: registered state block, combinational next-state block, output decode.
// TESTING (WIDTH=4, MODULUS=10, STEP_W=4 unless noted)
//  rst=1 for 2 cycles with mode=0, en=1
//    -> count=0, dir=0, wrap=0 throughout; count=1 on first edge after rst=0.
//  mode=0, step=3 from count=0 -> 3,6,9,2; wrap=1 only with the 9->2 update; tc=1 while count=9.
//  mode=2, step=4 from 0 -> 4,8,9(dir=1,wrap),5,1,0(dir=0,wrap),4.
//  mode=3, load_val=12 -> count=9, load_err=1 for 1 cycle; then load_val=7 -> count=7, load_err=0.
//  mode=1, step=1 from 0 -> 9 with wrap=1; en=0 for 3 cycles -> count frozen, wrap=0.
//  mode=6, step=5 from 7 -> 2,0,0; mode=2 then rst mid-DOWN -> count=0, dir=0.
//  Repeat with MODCNT_THERMO_EN: count=3 -> thermo=10'b0000000111.

Source files
------------

// File: rtl/modcounter_pkg.sv
// -----------------------------------------------------------------------------
// modcounter_pkg
// Shared constants for the multi-mode modulo counter family.
//   MODE_*      : encodings of the 3-bit mode input
//   ST_UP/DOWN  : bounce-direction states; they double as the dir output value
// -----------------------------------------------------------------------------
package modcounter_pkg;

  localparam logic [2:0] MODE_UP     = 3'd0;
  localparam logic [2:0] MODE_DOWN   = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_LOAD   = 3'd3;
  localparam logic [2:0] MODE_HOLD   = 3'd4;
  localparam logic [2:0] MODE_UPSAT  = 3'd5;
  localparam logic [2:0] MODE_DNSAT  = 3'd6;

  localparam logic ST_UP   = 1'b0;
  localparam logic ST_DOWN = 1'b1;

endpackage

// File: rtl/modcounter_thermo.sv
// -----------------------------------------------------------------------------
// modcounter_thermo
// Thermometer view of a counter value: bit i is set when i < count, so a count
// of 0 gives all zeros. Purely combinational.
//   i_count  in  WIDTH    counter value
//   o_thermo out MODULUS  thermometer code
// -----------------------------------------------------------------------------
module modcounter_thermo
  import modcounter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 200
) (
  input  logic [WIDTH-1:0]   i_count,
  output logic [MODULUS-1:0] o_thermo
);

  for (genvar i = 0; i < MODULUS; i++) begin : g_bit
    assign o_thermo[i] = (i_count > WIDTH'(i));
  end

endmodule

// File: rtl/modcounter_gen.sv
// -----------------------------------------------------------------------------
// modcounter_gen
// Parametrised multi-mode modulo counter (range 0..MODULUS-1) with programmable
// step, wrap/saturate/bounce/load modes, wrap and load-error pulses and a
// terminal-count flag.
//   clk       in   1        clock, all state on posedge
//   rst       in   1        synchronous active-high reset (priority over en)
//   en        in   1        count enable; 0 freezes count/dir
//   mode      in   3        0 up-wrap,1 down-wrap,2 bounce,3 load,4/7 hold,
//                           5 up-sat,6 down-sat
//   step      in   STEP_W   increment per enabled cycle (clamped to MODULUS-1)
//   load_val  in   WIDTH    value loaded in mode 3
//   count     out  WIDTH    registered count
//   dir       out  1        registered bounce direction (0 up, 1 down)
//   wrap      out  1        registered pulse on wrap / bounce reversal
//   tc        out  1        combinational terminal count for the current mode
//   load_err  out  1        registered pulse when load_val >= MODULUS
//   thermo    out  MODULUS  thermometer view of count (only when the macro
//                           MODCNT_THERMO_EN is defined)
// -----------------------------------------------------------------------------
module modcounter_gen
  import modcounter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 200,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              wrap,
  output logic              tc,
  output logic              load_err
`ifdef MODCNT_THERMO_EN
  ,
  output logic [MODULUS-1:0] thermo
`endif
);

  // Two guard bits keep count+step and count+MODULUS free of overflow.
  localparam int IW = WIDTH + 2;
  localparam int XW = (STEP_W > IW) ? STEP_W : IW;
  localparam logic [IW-1:0] MOD_I = IW'(MODULUS);
  localparam logic [IW-1:0] MAX_I = IW'(MODULUS - 1);
  localparam logic [XW-1:0] MAX_X = XW'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_wrap;
  logic             r_load_err;

  logic [IW-1:0]    w_cur;
  logic [XW-1:0]    w_step_x;
  logic [IW-1:0]    w_s;
  logic [IW-1:0]    w_sum;
  logic [IW-1:0]    w_load_x;
  logic [IW-1:0]    w_count_nxt;
  logic             w_dir_nxt;
  logic             w_wrap_nxt;
  logic             w_load_err_nxt;

  function automatic logic [IW-1:0] f_sat_up(input logic [IW-1:0] cur,
                                             input logic [IW-1:0] s);
    logic [IW-1:0] t;
    t = cur + s;
    return (t > MAX_I) ? MAX_I : t;
  endfunction

  function automatic logic [IW-1:0] f_sat_dn(input logic [IW-1:0] cur,
                                             input logic [IW-1:0] s);
    return (cur > s) ? (cur - s) : '0;
  endfunction

  // An out-of-range count is treated as MODULUS-1 for all arithmetic.
  assign w_cur    = (IW'(r_count) > MAX_I) ? MAX_I : IW'(r_count);
  assign w_step_x = XW'(step);
  assign w_s      = (w_step_x > MAX_X) ? MAX_I : IW'(w_step_x);
  assign w_sum    = w_cur + w_s;
  assign w_load_x = IW'(load_val);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_dir      <= ST_UP;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= WIDTH'(w_count_nxt);
      r_dir      <= w_dir_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_count_nxt    = IW'(r_count);
    w_dir_nxt      = r_dir;
    w_wrap_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    if (en) begin
      // Every mode except bounce parks the FSM in UP, so re-entering bounce
      // always starts upward.
      w_dir_nxt = ST_UP;
      case (mode)
        MODE_UP: begin
          if (w_s != '0) begin
            if (w_sum >= MOD_I) begin
              w_count_nxt = w_sum - MOD_I;
              w_wrap_nxt  = 1'b1;
            end else begin
              w_count_nxt = w_sum;
            end
          end
        end
        MODE_DOWN: begin
          if (w_s != '0) begin
            if (w_cur < w_s) begin
              w_count_nxt = w_cur + MOD_I - w_s;
              w_wrap_nxt  = 1'b1;
            end else begin
              w_count_nxt = w_cur - w_s;
            end
          end
        end
        MODE_BOUNCE: begin
          w_dir_nxt = r_dir;
          if (w_s != '0) begin
            if (r_dir == ST_UP) begin
              if (w_sum >= MAX_I) begin
                w_count_nxt = MAX_I;
                w_dir_nxt   = ST_DOWN;
                w_wrap_nxt  = 1'b1;
              end else begin
                w_count_nxt = w_sum;
              end
            end else begin
              if (w_cur <= w_s) begin
                w_count_nxt = '0;
                w_dir_nxt   = ST_UP;
                w_wrap_nxt  = 1'b1;
              end else begin
                w_count_nxt = w_cur - w_s;
              end
            end
          end
        end
        MODE_LOAD: begin
          if (w_load_x < MOD_I) begin
            w_count_nxt = w_load_x;
          end else begin
            w_count_nxt    = MAX_I;
            w_load_err_nxt = 1'b1;
          end
        end
        MODE_UPSAT: begin
          if (w_s != '0) w_count_nxt = f_sat_up(w_cur, w_s);
        end
        MODE_DNSAT: begin
          if (w_s != '0) w_count_nxt = f_sat_dn(w_cur, w_s);
        end
        MODE_HOLD: begin
          w_count_nxt = IW'(r_count);
        end
        default: begin
          w_count_nxt = IW'(r_count);
        end
      endcase
    end
  end

  // ---- output decode ----
  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP, MODE_UPSAT:   tc = (r_count == WIDTH'(MODULUS - 1));
      MODE_DOWN, MODE_DNSAT: tc = (r_count == '0);
      MODE_BOUNCE:           tc = (r_dir == ST_UP) ? (r_count == WIDTH'(MODULUS - 1))
                                                   : (r_count == '0);
      default:               tc = 1'b0;
    endcase
  end

  assign count    = r_count;
  assign dir      = r_dir;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

`ifdef MODCNT_THERMO_EN
  modcounter_thermo #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_thermo (
    .i_count  (r_count),
    .o_thermo (thermo)
  );
`endif

endmodule

// File: tb/tb_modcounter_gen.sv
module tb_modcounter_gen;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [SW-1:0] step;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic          dir;
  logic          wrap;
  logic          tc;
  logic          load_err;
`ifdef MODCNT_THERMO_EN
  logic [M-1:0]  thermo;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_cnt = 0;
  int m_dir = 0;
  int m_wrap = 0;
  int m_lerr = 0;
  bit m_valid = 0;

  modcounter_gen #(.WIDTH(W), .MODULUS(M), .STEP_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .step     (step),
    .load_val (load_val),
    .count    (count),
    .dir      (dir),
    .wrap     (wrap),
    .tc       (tc),
    .load_err (load_err)
`ifdef MODCNT_THERMO_EN
    ,
    .thermo   (thermo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_tc(input int md, input int c, input int d);
    if (md == 0 || md == 5 || (md == 2 && d == 0)) return (c == M - 1) ? 1 : 0;
    if (md == 1 || md == 6 || (md == 2 && d == 1)) return (c == 0) ? 1 : 0;
    return 0;
  endfunction

  // Drive one cycle of inputs, check combinational outputs, advance the model
  // across the next posedge and check the registered outputs just after it.
  task automatic cyc(input bit r, input bit e, input int md, input int st, input int lv);
    int s, nc, nd, nw, ne;
    rst = r; en = e; mode = 3'(md); step = SW'(st); load_val = W'(lv);
    #1;
    if (m_valid) begin
      chk("tc", 32'(tc), 32'(model_tc(md, m_cnt, m_dir)));
`ifdef MODCNT_THERMO_EN
      chk("thermo", 32'(thermo), 32'((1 << m_cnt) - 1));
`endif
    end
    s  = (st > M - 1) ? M - 1 : st;
    nc = m_cnt; nd = m_dir; nw = 0; ne = 0;
    if (r) begin
      nc = 0; nd = 0;
    end else if (e) begin
      nd = 0;
      case (md)
        0: if (s > 0) begin nw = (m_cnt + s >= M); nc = (m_cnt + s) % M; end
        1: if (s > 0) begin nw = (m_cnt < s); nc = (m_cnt - s + M) % M; end
        2: begin
          nd = m_dir;
          if (s > 0) begin
            if (m_dir == 0) begin
              if (m_cnt + s >= M - 1) begin nc = M - 1; nd = 1; nw = 1; end
              else nc = m_cnt + s;
            end else begin
              if (m_cnt <= s) begin nc = 0; nd = 0; nw = 1; end
              else nc = m_cnt - s;
            end
          end
        end
        3: if (lv < M) nc = lv; else begin nc = M - 1; ne = 1; end
        5: nc = (m_cnt + s > M - 1) ? M - 1 : m_cnt + s;
        6: nc = (m_cnt > s) ? m_cnt - s : 0;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_cnt = nc; m_dir = nd; m_wrap = nw; m_lerr = ne;
    m_valid = 1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("load_err", 32'(load_err), 32'(m_lerr));
  endtask

  int exp_b[7] = '{4, 8, 9, 5, 1, 0, 4};
  int exp_d[7] = '{0, 0, 1, 1, 1, 0, 0};

  initial begin
    rst = 1'b1; en = 1'b1; mode = 3'd0; step = 4'd1; load_val = '0;

    // reset held for two cycles with counting requested
    cyc(1, 1, 0, 1, 0);
    chk("rst1_count", 32'(count), 0);
    cyc(1, 1, 0, 1, 0);
    chk("rst2_count", 32'(count), 0);
    chk("rst2_wrap", 32'(wrap), 0);
    cyc(0, 1, 0, 1, 0);
    chk("rst_release", 32'(count), 1);

    // up-wrap by 3
    cyc(1, 1, 0, 3, 0);
    cyc(0, 1, 0, 3, 0); chk("up_a", 32'(count), 3);
    cyc(0, 1, 0, 3, 0); chk("up_b", 32'(count), 6);
    cyc(0, 1, 0, 3, 0); chk("up_c", 32'(count), 9); chk("up_c_wrap", 32'(wrap), 0);
    chk("up_tc", 32'(tc), 1);
    cyc(0, 1, 0, 3, 0); chk("up_d", 32'(count), 2); chk("up_d_wrap", 32'(wrap), 1);

    // bounce by 4
    cyc(1, 1, 2, 4, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 2, 4, 0);
      chk("bounce_cnt", 32'(count), 32'(exp_b[i]));
      chk("bounce_dir", 32'(dir), 32'(exp_d[i]));
    end

    // load out of range then in range
    cyc(0, 1, 3, 0, 12); chk("load_bad", 32'(count), 9); chk("load_bad_err", 32'(load_err), 1);
    cyc(0, 1, 3, 0, 7);  chk("load_ok", 32'(count), 7);  chk("load_ok_err", 32'(load_err), 0);

    // down-wrap from 0, then frozen
    cyc(1, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0); chk("dn_wrap_cnt", 32'(count), 9); chk("dn_wrap", 32'(wrap), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 0);
      chk("frz_cnt", 32'(count), 9); chk("frz_wrap", 32'(wrap), 0);
    end

    // down-saturate by 5 from 7
    cyc(0, 1, 3, 0, 7);
    cyc(0, 1, 6, 5, 0); chk("dsat_a", 32'(count), 2);
    cyc(0, 1, 6, 5, 0); chk("dsat_b", 32'(count), 0);
    cyc(0, 1, 6, 5, 0); chk("dsat_c", 32'(count), 0);

    // bounce into DOWN, then reset mid-run
    cyc(1, 1, 2, 4, 0);
    cyc(0, 1, 2, 4, 0);
    cyc(0, 1, 2, 4, 0);
    cyc(0, 1, 2, 4, 0);
    cyc(0, 1, 2, 4, 0); chk("mid_dir", 32'(dir), 1);
    cyc(1, 1, 2, 4, 0); chk("mid_rst_cnt", 32'(count), 0); chk("mid_rst_dir", 32'(dir), 0);

`ifdef MODCNT_THERMO_EN
    cyc(0, 1, 3, 0, 3);
    #1;
    chk("thermo3", 32'(thermo), 32'(10'b0000000111));
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
